// File: rtl/tone_scheduler.sv
// Fixed-priority scheduler sharing one square-wave tone generator between
// NUM_REQ requesters. Times each tone in milliseconds, inserts a silent gap
// between tones and reports completion or preemption per requester.
module tone_scheduler #(
    parameter int NUM_REQ = 3,
    parameter int FREQ_W  = 10,
    parameter int DUR_W   = 10,
    parameter int GAP_MS  = 20
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [15:0]                 ticks_per_milli,
    input  logic                        mute,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*FREQ_W-1:0]   req_freq,
    input  logic [NUM_REQ*DUR_W-1:0]    req_dur_ms,
    output logic [NUM_REQ-1:0]          grant,
    output logic [NUM_REQ-1:0]          done,
    output logic [NUM_REQ-1:0]          abort,
    output logic                        busy,
    output logic [FREQ_W-1:0]           freq
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int MS_W  = 16;

    typedef enum logic [1:0] {IDLE, TONE, GAP} state_t;

    state_t                 state, state_next;
    logic [15:0]            tick_cnt;
    logic [MS_W-1:0]        ms_cnt;
    logic [FREQ_W-1:0]      lat_freq;
    logic [DUR_W-1:0]       lat_dur;
    logic [IDX_W-1:0]       owner;

    logic                   any_req;
    logic [IDX_W-1:0]       top_idx;
    logic [FREQ_W-1:0]      sel_freq;
    logic [DUR_W-1:0]       sel_dur;
    logic [15:0]            tpm_eff;
    logic                   tick_wrap;
    logic [MS_W:0]          ms_inc;
    logic                   tone_end, gap_end;
    logic                   start, preempt, cancel, finish, load, clear_timer;

    logic [NUM_REQ-1:0]     grant_n, done_n, abort_n;
    logic                   busy_n;
    logic [FREQ_W-1:0]      freq_n;

    // Priority encoder: lowest set request index wins, plus its slot data.
    always_comb begin
        any_req = 1'b0;
        top_idx = '0;
        for (int unsigned i = NUM_REQ; i > 0; i--) begin
            if (req[i-1]) begin
                any_req = 1'b1;
                top_idx = IDX_W'(i - 1);
            end
        end
        sel_freq = req_freq[top_idx*FREQ_W +: FREQ_W];
        sel_dur  = req_dur_ms[top_idx*DUR_W +: DUR_W];
    end

    // Timer compares and per-cycle events; preemption outranks cancel,
    // which outranks normal completion.
    always_comb begin
        tpm_eff     = (ticks_per_milli == 16'd0) ? 16'd1 : ticks_per_milli;
        tick_wrap   = (tick_cnt >= tpm_eff - 16'd1);
        ms_inc      = {1'b0, ms_cnt} + (MS_W+1)'(1);
        tone_end    = (lat_dur == '0) || (tick_wrap && (ms_inc >= (MS_W+1)'(lat_dur)));
        gap_end     = (GAP_MS == 0) || (tick_wrap && (ms_inc >= (MS_W+1)'(GAP_MS)));
        start       = (state == IDLE) && any_req;
        preempt     = (state == TONE) && any_req && (top_idx < owner);
        cancel      = (state == TONE) && !preempt && !req[owner];
        finish      = (state == TONE) && !preempt && !cancel && tone_end;
        load        = start || preempt;
        clear_timer = load || cancel || finish || ((state == GAP) && gap_end);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = TONE;
            TONE:    if (!preempt && (cancel || finish)) state_next = GAP;
            GAP:     if (gap_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Latched request data and the tick/ms timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_freq <= '0;
            lat_dur  <= '0;
            owner    <= '0;
            tick_cnt <= '0;
            ms_cnt   <= '0;
        end else begin
            if (load) begin
                lat_freq <= sel_freq;
                lat_dur  <= sel_dur;
                owner    <= top_idx;
            end
            if (clear_timer || state == IDLE) begin
                tick_cnt <= '0;
                ms_cnt   <= '0;
            end else if (tick_wrap) begin
                tick_cnt <= '0;
                ms_cnt   <= ms_cnt + MS_W'(1);
            end else begin
                tick_cnt <= tick_cnt + 16'd1;
            end
        end
    end

    // Output decode: next values of the registered outputs.
    always_comb begin
        grant_n = '0;
        done_n  = '0;
        abort_n = '0;
        busy_n  = 1'b0;
        freq_n  = '0;
        if (preempt || cancel) abort_n[owner] = 1'b1;
        if (finish)            done_n[owner]  = 1'b1;
        case (state_next)
            TONE: begin
                busy_n = 1'b1;
                if (load) begin
                    grant_n = NUM_REQ'(1) << top_idx;
                    freq_n  = (mute || sel_dur == '0) ? '0 : sel_freq;
                end else begin
                    grant_n = NUM_REQ'(1) << owner;
                    freq_n  = mute ? '0 : lat_freq;
                end
            end
            GAP:     busy_n = 1'b1;
            default: busy_n = 1'b0;
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant <= '0;
            done  <= '0;
            abort <= '0;
            busy  <= 1'b0;
            freq  <= '0;
        end else begin
            grant <= grant_n;
            done  <= done_n;
            abort <= abort_n;
            busy  <= busy_n;
            freq  <= freq_n;
        end
    end

endmodule

// File: tb/tb_tone_scheduler.sv
// Self-checking bench for tone_scheduler: table of single-tone vectors plus
// hand-written preemption, cancel, repeat and reset sequences.
module tb_tone_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ticks_per_milli;
    logic        mute;
    logic [2:0]  req;
    logic [29:0] req_freq;
    logic [29:0] req_dur_ms;
    logic [2:0]  grant, done, abort;
    logic        busy;
    logic [9:0]  freq;

    int total = 0;
    int bad   = 0;

    tone_scheduler #(.NUM_REQ(3), .FREQ_W(10), .DUR_W(10), .GAP_MS(2)) dut (
        .clk(clk), .rst(rst), .ticks_per_milli(ticks_per_milli), .mute(mute),
        .req(req), .req_freq(req_freq), .req_dur_ms(req_dur_ms),
        .grant(grant), .done(done), .abort(abort), .busy(busy), .freq(freq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  rq;
        logic [29:0] freqs;
        logic [29:0] durs;
        logic        mt;
        logic [2:0]  g;
        int          f;
        int          cycles;
        int          nz;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(output int n);
        n = 0;
        while (grant == 3'b000 && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_done(output int n, output int nz);
        n = 0;
        nz = (freq != 0) ? 1 : 0;
        while (n < 200) begin
            tick();
            n++;
            if (done != 3'b000) break;
            if (freq != 0) nz++;
        end
    endtask

    task automatic wait_idle(output int m, output logic [2:0] first_done);
        m = 0;
        first_done = 3'b000;
        while (n_busy_guard(m)) begin
            tick();
            m++;
            if (m == 1) first_done = done;
            if (!busy) break;
        end
    endtask

    function automatic bit n_busy_guard(input int m);
        return m < 100;
    endfunction

    int n, nz, m;
    logic [2:0] fd;

    initial begin
        // slot packing: {slot2, slot1, slot0}
        vecs[0] = '{3'b100, {10'd262, 10'd0,   10'd0   }, {10'd5, 10'd0, 10'd0}, 1'b0, 3'b100, 262,  20, 20};
        vecs[1] = '{3'b010, {10'd0,   10'd500, 10'd0   }, {10'd0, 10'd3, 10'd0}, 1'b0, 3'b010, 500,  12, 12};
        vecs[2] = '{3'b001, {10'd0,   10'd0,   10'd784 }, {10'd0, 10'd0, 10'd1}, 1'b0, 3'b001, 784,  4,  4};
        vecs[3] = '{3'b110, {10'd262, 10'd440, 10'd0   }, {10'd9, 10'd2, 10'd0}, 1'b0, 3'b010, 440,  8,  8};
        vecs[4] = '{3'b010, {10'd0,   10'd600, 10'd0   }, {10'd0, 10'd0, 10'd0}, 1'b0, 3'b010, 0,    1,  0};
        vecs[5] = '{3'b100, {10'd262, 10'd0,   10'd0   }, {10'd5, 10'd0, 10'd0}, 1'b1, 3'b100, 0,    20, 0};
        vecs[6] = '{3'b011, {10'd0,   10'd300, 10'd1023}, {10'd0, 10'd4, 10'd2}, 1'b0, 3'b001, 1023, 8,  8};

        rst = 1'b1;
        ticks_per_milli = 16'd4;
        mute = 1'b0;
        req = 3'b000;
        req_freq = '0;
        req_dur_ms = '0;
        repeat (2) tick();
        check("reset_grant", int'(grant), 0);
        check("reset_busy",  int'(busy),  0);
        check("reset_freq",  int'(freq),  0);
        check("reset_done_abort", int'({done, abort}), 0);
        rst = 1'b0;
        tick();

        for (int v = 0; v < 7; v++) begin
            req_freq   = vecs[v].freqs;
            req_dur_ms = vecs[v].durs;
            mute       = vecs[v].mt;
            req        = vecs[v].rq;
            wait_grant(n);
            check($sformatf("v%0d_grant", v), int'(grant), int'(vecs[v].g));
            check($sformatf("v%0d_freq", v),  int'(freq),  vecs[v].f);
            check($sformatf("v%0d_busy", v),  int'(busy),  1);
            wait_done(n, nz);
            check($sformatf("v%0d_tone_cycles", v), n, vecs[v].cycles);
            check($sformatf("v%0d_done", v), int'(done), int'(vecs[v].g));
            check($sformatf("v%0d_nonzero", v), nz, vecs[v].nz);
            req = 3'b000;
            mute = 1'b0;
            wait_idle(m, fd);
            check($sformatf("v%0d_done_pulse", v), int'(fd), 0);
            check($sformatf("v%0d_gap", v), m, 8);
        end

        // Preemption: req2 dur 10, req0 (784, 3 ms) arrives at ms 4.
        req_freq   = {10'd300, 10'd0, 10'd784};
        req_dur_ms = {10'd10,  10'd0, 10'd3};
        req = 3'b100;
        wait_grant(n);
        check("pre_grant2", int'(grant), 4);
        repeat (16) tick();
        check("pre_freq_before", int'(freq), 300);
        req = 3'b101;
        tick();
        check("pre_abort", int'(abort), 4);
        check("pre_grant0", int'(grant), 1);
        check("pre_freq784", int'(freq), 784);
        check("pre_busy", int'(busy), 1);
        req = 3'b001;
        wait_done(n, nz);
        check("pre_done_cycles", n, 12);
        check("pre_done", int'(done), 1);
        req = 3'b000;
        wait_idle(m, fd);
        check("pre_gap", m, 8);

        // Cancel: req1 dropped mid-tone.
        req_freq   = {10'd0, 10'd523, 10'd0};
        req_dur_ms = {10'd0, 10'd10,  10'd0};
        req = 3'b010;
        wait_grant(n);
        repeat (5) tick();
        req = 3'b000;
        tick();
        check("cancel_abort", int'(abort), 2);
        check("cancel_grant", int'(grant), 0);
        check("cancel_freq",  int'(freq),  0);
        check("cancel_done",  int'(done),  0);
        check("cancel_busy",  int'(busy),  1);
        wait_idle(m, fd);
        check("cancel_gap", m, 8);

        // Repeat/priority: req=110 serves req1, then req2 after gap + 1.
        req_freq   = {10'd262, 10'd440, 10'd0};
        req_dur_ms = {10'd1,   10'd2,   10'd0};
        req = 3'b110;
        wait_grant(n);
        check("rep_grant1", int'(grant), 2);
        wait_done(n, nz);
        check("rep_done1", int'(done), 2);
        req = 3'b100;
        m = 0;
        while (grant == 3'b000 && m < 50) begin
            tick();
            m++;
        end
        check("rep_spacing", m, 9);
        check("rep_grant2", int'(grant), 4);
        check("rep_freq2", int'(freq), 262);

        // Asynchronous reset mid-tone.
        repeat (2) tick();
        rst = 1'b1;
        #1;
        check("arst_freq",  int'(freq),  0);
        check("arst_grant", int'(grant), 0);
        check("arst_busy",  int'(busy),  0);
        req = 3'b000;
        tick();
        rst = 1'b0;
        tick();
        check("arst_idle_busy", int'(busy), 0);
        check("arst_idle_grant", int'(grant), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
